// File: rtl/chdr_conv_chain_sel_pkg.sv
// rtl/chdr_conv_chain_sel_pkg.sv - shared chdr register offsets, path-ID sizing and FSM state types
package chdr_conv_chain_sel_pkg;

  localparam int SR_PATH_SEL  = 0;
  localparam int SR_CNT_CLEAR = 1;

  // Path-ID width is clog2(NUM_PATHS), but never narrower than one bit.
  function automatic int path_id_w(input int num_paths);
    return (num_paths <= 2) ? 1 : $clog2(num_paths);
  endfunction

  typedef enum logic {ING_IDLE, ING_PKT} ing_state_t;
  typedef enum logic {EGR_WAIT, EGR_PKT} egr_state_t;

endpackage

// File: rtl/chdr_conv_order_fifo.sv
// rtl/chdr_conv_order_fifo.sv - synchronous FIFO of path IDs recording ingress packet order
module chdr_conv_order_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot a same-cycle push needs, and a push supplies the
  // entry a same-cycle pop consumes, so both succeed at full and at empty.
  assign wr_en   = push && (!full || pop);
  assign rd_en   = pop && (!empty || push);
  assign rd_data = mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

  // Storage write; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/chdr_conv_chain_sel.sv
// rtl/chdr_conv_chain_sel.sv - routes packets through one of several converter paths, preserving packet order
module chdr_conv_chain_sel
  import chdr_conv_chain_sel_pkg::*;
#(
  parameter int BASE        = 0,
  parameter int NUM_PATHS   = 4,
  parameter int WIDTH       = 64,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           set_stb,
  input  logic [7:0]                     set_addr,
  input  logic [31:0]                    set_data,
  input  logic [WIDTH-1:0]               i_tdata,
  input  logic                           i_tlast,
  input  logic                           i_tvalid,
  output logic                           i_tready,
  output logic [WIDTH-1:0]               o_tdata,
  output logic                           o_tlast,
  output logic                           o_tvalid,
  input  logic                           o_tready,
  output logic [(NUM_PATHS-1)*WIDTH-1:0] cv_o_tdata,
  output logic [NUM_PATHS-2:0]           cv_o_tlast,
  output logic [NUM_PATHS-2:0]           cv_o_tvalid,
  input  logic [NUM_PATHS-2:0]           cv_o_tready,
  input  logic [(NUM_PATHS-1)*WIDTH-1:0] cv_i_tdata,
  input  logic [NUM_PATHS-2:0]           cv_i_tlast,
  input  logic [NUM_PATHS-2:0]           cv_i_tvalid,
  output logic [NUM_PATHS-2:0]           cv_i_tready,
  output logic [31:0]                    debug
);

  localparam int PW = path_id_w(NUM_PATHS);
  localparam int NL = NUM_PATHS - 1;

  logic [2:0]    path_sel;
  logic          err_flag;
  logic [15:0]   ing_cnt;
  logic [15:0]   egr_cnt;
  logic          wr_sel;
  logic          wr_clr;
  logic          bad_sel_wr;
  logic [PW-1:0] sel_eff;
  logic [PW-1:0] ing_lat;
  logic [PW-1:0] ing_path;
  logic [PW-1:0] head;
  ing_state_t    ing_state;
  ing_state_t    ing_next;
  egr_state_t    egr_state;
  egr_state_t    egr_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          ing_room;
  logic          bypass;
  logic          egr_on;
  logic          p0_go;
  logic          path_rdy;
  logic          ing_fire;
  logic          egr_fire;
  logic          unused_set_data;

  assign unused_set_data = ^set_data[31:3];

  assign wr_sel     = set_stb && (set_addr == 8'(BASE + SR_PATH_SEL));
  assign wr_clr     = set_stb && (set_addr == 8'(BASE + SR_CNT_CLEAR));
  assign bad_sel_wr = wr_sel && (int'(set_data[2:0]) >= NUM_PATHS);

  // Out-of-range selections fall back to the internal pass-through path.
  assign sel_eff  = (int'(path_sel) < NUM_PATHS) ? PW'(path_sel) : '0;
  assign ing_path = (ing_state == ING_PKT) ? ing_lat : sel_eff;
  // Only a packet start needs a free order slot.
  assign ing_room = (ing_state == ING_PKT) || !fifo_full;
  // A path-0 packet start can only flow when nothing older is outstanding;
  // its ID is pushed and, for a one-beat packet, popped in the same cycle.
  assign bypass   = (egr_state == EGR_WAIT) && fifo_empty &&
                    (ing_state == ING_IDLE) && (sel_eff == '0);
  assign egr_on   = (egr_state == EGR_PKT) || bypass;

  assign ing_fire = i_tvalid && i_tready;
  assign egr_fire = o_tvalid && o_tready;
  assign push     = ing_fire && (ing_state == ING_IDLE);
  assign pop      = egr_fire && o_tlast;
  assign debug    = {ing_cnt, egr_cnt};

  chdr_conv_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .W     (PW)
  ) u_order_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (sel_eff),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Settings registers: path select and sticky bad-select flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      path_sel <= '0;
      err_flag <= 1'b0;
    end else begin
      if (wr_sel) path_sel <= set_data[2:0];
      err_flag <= (err_flag || bad_sel_wr) && !wr_clr;
    end
  end

  // Packet counters; a clear write takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || wr_clr) begin
      ing_cnt <= '0;
      egr_cnt <= '0;
    end else begin
      if (ing_fire && i_tlast) ing_cnt <= ing_cnt + 16'd1;
      if (pop)                 egr_cnt <= egr_cnt + 16'd1;
    end
  end

  // FSM state registers and the path latched at each packet start.
  always_ff @(posedge clk) begin
    if (reset) begin
      ing_state <= ING_IDLE;
      egr_state <= EGR_WAIT;
      ing_lat   <= '0;
    end else begin
      ing_state <= ing_next;
      egr_state <= egr_next;
      if (push) ing_lat <= sel_eff;
    end
  end

  // Next-state logic for the ingress and egress FSMs.
  always_comb begin
    ing_next = ing_state;
    egr_next = egr_state;
    case (ing_state)
      ING_IDLE: if (push && !i_tlast)    ing_next = ING_PKT;
      ING_PKT:  if (ing_fire && i_tlast) ing_next = ING_IDLE;
      default:                           ing_next = ING_IDLE;
    endcase
    case (egr_state)
      EGR_WAIT: begin
        if (egr_fire)         egr_next = o_tlast ? EGR_WAIT : EGR_PKT;
        else if (!fifo_empty) egr_next = EGR_PKT;
      end
      EGR_PKT:  if (pop) egr_next = EGR_WAIT;
      default:           egr_next = EGR_WAIT;
    endcase
  end

  // Zero-latency stream steering on both sides of the converters.
  always_comb begin
    cv_o_tdata  = {NL{i_tdata}};
    cv_o_tlast  = {NL{i_tlast}};
    cv_o_tvalid = '0;
    cv_i_tready = '0;
    o_tdata     = i_tdata;
    o_tlast     = i_tlast;
    o_tvalid    = 1'b0;
    path_rdy    = 1'b0;
    p0_go       = !reset && egr_on && ((egr_state == EGR_WAIT) || (head == '0));
    if (p0_go) o_tvalid = i_tvalid && (ing_path == '0);
    if (ing_path == '0) path_rdy = p0_go && o_tready;
    for (int k = 1; k < NUM_PATHS; k++) begin
      if (!reset && ing_room && (ing_path == PW'(k))) begin
        cv_o_tvalid[k-1] = i_tvalid;
        path_rdy         = cv_o_tready[k-1];
      end
      if (!reset && (egr_state == EGR_PKT) && (head == PW'(k))) begin
        o_tdata          = cv_i_tdata[(k-1)*WIDTH +: WIDTH];
        o_tlast          = cv_i_tlast[k-1];
        o_tvalid         = cv_i_tvalid[k-1];
        cv_i_tready[k-1] = o_tready;
      end
    end
    i_tready = !reset && ing_room && path_rdy;
  end

endmodule

// File: doc/chdr_conv_chain_sel.md
CHDR_CONV_CHAIN_SEL -- requirements
Module: chdr_conv_chain_sel

Interface
REQ-001 Parameter BASE, 0, settings-bus base address.
REQ-002 Parameter NUM_PATHS, 4, total conversion paths (2..8); path 0 is internal pass-through, paths 1..NUM_PATHS-1 are external converters.
REQ-003 Parameter WIDTH, 64, AXI-stream data width.
REQ-004 Parameter ORDER_DEPTH, 8, packet-order FIFO depth (power of 2, 2..32).
REQ-005 The block has one clock, clk, and reset is synchronous and active-high, named reset.
REQ-006 clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-007 set_stb  in  1; set_addr  in  8; set_data  in  32  settings bus.
REQ-008 i_tdata  in  WIDTH; i_tlast  in  1; i_tvalid  in  1; i_tready  out  1  ingress stream.
REQ-009 o_tdata  out  WIDTH; o_tlast  out  1; o_tvalid  out  1; o_tready  in  1  egress stream.
REQ-010 cv_o_tdata  out  (NUM_PATHS-1)*WIDTH; cv_o_tlast/cv_o_tvalid  out  NUM_PATHS-1; cv_o_tready  in  NUM_PATHS-1  to converters, lane k-1 = path k.
REQ-011 cv_i_tdata  in  (NUM_PATHS-1)*WIDTH; cv_i_tlast/cv_i_tvalid  in  NUM_PATHS-1; cv_i_tready  out  NUM_PATHS-1  from converters.
REQ-012 debug  out  32  {ingress packet count[15:0], egress packet count[15:0]}.

Function
REQ-013 Register BASE+0 bits[2:0] = path_sel, reset 0; register BASE+1 write (any data) clears both packet counters.
REQ-014 path_sel >= NUM_PATHS routes to path 0 and sets sticky error flag, cleared by BASE+1 write.
REQ-015 Ingress FSM states IDLE, PKT; IDLE latches effective path_sel on first accepted beat, pushes path ID into order FIFO, goes to PKT unless beat has tlast.
REQ-016 PKT forwards beats to latched path; accepted tlast returns to IDLE; path_sel writes mid-packet never affect current packet.
REQ-017 Settings write in same cycle as first beat: first beat uses the old path_sel.
REQ-018 Ingress routing is combinational (zero latency); i_tready = selected path ready AND (state PKT OR order FIFO not full).
REQ-019 Unselected cv_o_tvalid lanes SHALL be 0.
REQ-020 Egress FSM states WAIT, PKT; WAIT leaves when order FIFO non-empty; PKT forwards from path at FIFO head, pops FIFO on accepted tlast.
REQ-021 Egress routing combinational; non-head cv_i_tready lanes held 0; egress order equals ingress packet order.
REQ-022 Path 0 data is i_* directly; path-0 ingress beats only complete when egress head is path 0 (backpressure, no loss).
REQ-023 Order FIFO simultaneous push and pop when full or empty SHALL both succeed without count change.
REQ-024 Packet counters increment on accepted tlast (ingress/egress), 16-bit wrap 0xFFFF->0x0000; clear write wins over increment.

Reset
REQ-025 While reset high: i_tready=0, o_tvalid=0, all cv_o_tvalid=0, all cv_i_tready=0.
REQ-026 Reset (including mid-packet) returns both FSMs to IDLE/WAIT, empties order FIFO, path_sel=0, counters=0, error flag=0.

Structure
REQ-027 Register offsets SR_PATH_SEL=0, SR_CNT_CLEAR=1 and path-ID width clog2(NUM_PATHS) live in the shared chdr constants include.
REQ-028 One sub-module chdr_conv_order_fifo (synchronous FIFO, full/empty flags) holds path IDs.

Verification
REQ-029 Reset, path_sel=0, 3-beat packet 0xA..0xC -> o emits identical beats, debug=0x00010001.
REQ-030 path_sel=2, send packet; write path_sel=1 on beat 2 -> whole packet on lane 1 (path 2), next packet on lane 0.
REQ-031 Packets to path 2 (slow converter, 10-cycle delay) then path 1 (fast) -> egress order path 2 then path 1.
REQ-032 Hold o_tready=0, send ORDER_DEPTH single-beat packets on path 1 -> i_tready=0 on packet ORDER_DEPTH+1 first beat, no loss after release.
REQ-033 path_sel=7 with NUM_PATHS=4 -> traffic on path 0, error flag set; BASE+1 write clears flag and counters.
REQ-034 Assert reset mid-packet on path 3 -> all valids/readies 0, debug=0, next packet routes via path 0.
